// File: rtl/jtdd_vtimer.sv
// Parametrised video timing generator: raster counters, blanking/sync levels,
// flip-aware pixel position, delayed blanking, frame and raster-interrupt pulses.
module jtdd_vtimer #(
  parameter int unsigned HW         = 9,
  parameter int unsigned VW         = 9,
  parameter int unsigned HTOTAL     = 384,
  parameter int unsigned HACT       = 256,
  parameter int unsigned HS_START   = 288,
  parameter int unsigned HS_END     = 320,
  parameter int unsigned VTOTAL     = 264,
  parameter int unsigned VACT       = 240,
  parameter int unsigned VS_START   = 248,
  parameter int unsigned VS_END     = 251,
  parameter int unsigned IRQ_PERIOD = 16,
  parameter int unsigned IRQ_PHASE  = 8,
  parameter int unsigned DLY        = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          flip,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic [HW-1:0] HPOS,
  output logic [VW-1:0] VPOS,
  output logic          HBL,
  output logic          VBL,
  output logic          HS,
  output logic          VS,
  output logic          LHBL_dly,
  output logic          LVBL_dly,
  output logic          irq,
  output logic          frame,
  output logic          flip_q
);

  localparam logic [HW-1:0] H_LAST     = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(HACT);
  localparam logic [HW-1:0] H_ACT_M1   = HW'(HACT - 1);
  localparam logic [HW:0]   H_SS       = (HW+1)'(HS_START);
  localparam logic [HW:0]   H_SE       = (HW+1)'(HS_END);
  localparam logic [VW-1:0] V_LAST     = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(VACT);
  localparam logic [VW-1:0] V_ACT_M1   = VW'(VACT - 1);
  localparam logic [VW:0]   V_SS       = (VW+1)'(VS_START);
  localparam logic [VW:0]   V_SE       = (VW+1)'(VS_END);
  localparam logic [VW-1:0] V_IRQ_MASK = VW'(IRQ_PERIOD - 1);
  localparam logic [VW-1:0] V_IRQ_PH   = VW'(IRQ_PHASE);

  localparam bit PARAMS_OK =
      (HACT < HTOTAL) && (HTOTAL <= 2**HW) &&
      (HS_START < HS_END) && (HS_END <= HTOTAL) &&
      (VACT < VTOTAL) && (VTOTAL <= 2**VW) &&
      (VS_START < VS_END) && (VS_END <= VTOTAL) &&
      (IRQ_PERIOD > 0) && ((IRQ_PERIOD & (IRQ_PERIOD - 1)) == 0) &&
      (IRQ_PHASE < IRQ_PERIOD) && (DLY >= 1) && (DLY <= 8);

  logic [HW-1:0]  h_nxt, hpos_nxt;
  logic [VW-1:0]  v_nxt, vpos_nxt;
  logic           h_wrap, frame_nxt, flip_nxt, h_act, v_act;
  logic           hs_nxt, vs_nxt, irq_nxt, hbl_in, vbl_in;
  logic [DLY-1:0] hbl_sr, vbl_sr;

  // Next-state values; every registered output is derived from these so it
  // moves on the same edge as the counters.
  always_comb begin
    h_wrap    = (hcnt == H_LAST);
    h_nxt     = h_wrap ? '0 : hcnt + 1'b1;
    v_nxt     = vcnt;
    if (h_wrap) v_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    frame_nxt = h_wrap && (vcnt == V_LAST);
    flip_nxt  = frame_nxt ? flip : flip_q;
    h_act     = (h_nxt < H_ACT);
    v_act     = (v_nxt < V_ACT);
    hpos_nxt  = (flip_nxt && h_act) ? H_ACT_M1 - h_nxt : h_nxt;
    vpos_nxt  = (flip_nxt && v_act) ? V_ACT_M1 - v_nxt : v_nxt;
    hs_nxt    = ({1'b0, h_nxt} >= H_SS) && ({1'b0, h_nxt} < H_SE);
    vs_nxt    = ({1'b0, v_nxt} >= V_SS) && ({1'b0, v_nxt} < V_SE);
    irq_nxt   = h_wrap && v_act && ((v_nxt & V_IRQ_MASK) == V_IRQ_PH);
    hbl_in    = ~HBL;
    vbl_in    = ~VBL;
  end

  // Pulses self-clear every clk; everything else only advances on pxl_cen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt   <= '0;
      vcnt   <= '0;
      HPOS   <= '0;
      VPOS   <= '0;
      HBL    <= 1'b0;
      VBL    <= 1'b0;
      HS     <= 1'b0;
      VS     <= 1'b0;
      irq    <= 1'b0;
      frame  <= 1'b0;
      flip_q <= 1'b0;
      hbl_sr <= '0;
      vbl_sr <= '0;
    end else begin
      irq   <= 1'b0;
      frame <= 1'b0;
      if (pxl_cen) begin
        hcnt   <= h_nxt;
        vcnt   <= v_nxt;
        HPOS   <= hpos_nxt;
        VPOS   <= vpos_nxt;
        HBL    <= ~h_act;
        VBL    <= ~v_act;
        HS     <= hs_nxt;
        VS     <= vs_nxt;
        irq    <= irq_nxt;
        frame  <= frame_nxt;
        flip_q <= flip_nxt;
        hbl_sr <= (hbl_sr << 1) | DLY'(hbl_in);
        vbl_sr <= (vbl_sr << 1) | DLY'(vbl_in);
      end
    end
  end

  assign LHBL_dly = hbl_sr[DLY-1];
  assign LVBL_dly = vbl_sr[DLY-1];

  // Elaboration-constant geometry check, simulation only.
  always_ff @(posedge clk) begin : param_chk
    assert (PARAMS_OK) else $error("jtdd_vtimer: illegal parameter set");
  end

endmodule

// File: doc/jtdd_vtimer.md
Name: jtdd_vtimer

Overview:
Parametrised video timing generator for the video subsystem. It produces horizontal and vertical counters, blanking and sync signals, flipped pixel positions and a programmable raster interrupt. It replaces the fixed-geometry timing unit and feeds the char, scroll, object and colour-mix layers. New capabilities over the fixed unit:
- configurable geometry
- a configurable delay line on the blanking outputs
- flip sampled only at frame start
- interrupt period and phase selectable by parameter

Parameters:
HW, 9, horizontal counter width
VW, 9, vertical counter width
HTOTAL, 384, pixels per line (counter wraps at HTOTAL-1)
HACT, 256, active pixels per line; hcnt 0..HACT-1 is visible
HS_START, 288, hcnt value where HS rises
HS_END, 320, hcnt value where HS falls (exclusive)
VTOTAL, 264, lines per frame
VACT, 240, active lines; vcnt 0..VACT-1 is visible
VS_START, 248, vcnt value where VS rises
VS_END, 251, vcnt value where VS falls (exclusive)
IRQ_PERIOD, 16, raster interrupt line period; must be a power of two
IRQ_PHASE, 8, line within each period that fires the interrupt
DLY, 2, pxl_cen ticks of delay on LHBL_dly and LVBL_dly (1..8)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
pxl_cen  in  1  pixel clock enable
flip  in  1  screen flip request
hcnt  out  HW  raw horizontal counter
vcnt  out  VW  raw vertical counter
HPOS  out  HW  horizontal position, flip applied
VPOS  out  VW  vertical position, flip applied
HBL  out  1  horizontal blank, active high
VBL  out  1  vertical blank, active high
HS  out  1  horizontal sync, active high
VS  out  1  vertical sync, active high
LHBL_dly  out  1  ~HBL delayed by DLY pxl_cen ticks
LVBL_dly  out  1  ~VBL delayed by DLY pxl_cen ticks
irq  out  1  raster interrupt pulse, one clk wide
frame  out  1  frame-start pulse, one clk wide
flip_q  out  1  flip value latched for the current frame

Behaviour:
Clock and reset
- One clock (clk). Reset (rst) is asynchronous and active-low.
- All state changes only on clk edges with pxl_cen=1, except pulse clearing (see irq/frame).

Reset values
- hcnt=0, vcnt=0, HPOS=0, VPOS=0.
- HBL=0, VBL=0, HS=0, VS=0, irq=0, frame=0, flip_q=0.
- Delay lines all 0, so LHBL_dly=0 and LVBL_dly=0 until DLY ticks have passed.
- Reset mid-frame returns to these values immediately; counting resumes at the first pxl_cen after release.

Counters
- hcnt increments on each pxl_cen and wraps HTOTAL-1 -> 0.
- vcnt increments when hcnt wraps, and wraps VTOTAL-1 -> 0.

Registered outputs
- All outputs are registered and computed from the next counter values, so they change on the same edge as hcnt/vcnt (zero-cycle skew relative to the counters).
- HBL = (hcnt >= HACT); VBL = (vcnt >= VACT).
- HS = (HS_START <= hcnt < HS_END); VS = (VS_START <= vcnt < VS_END).
- VS changes only on the hcnt wrap edge.

Flip
- flip_q samples flip on the edge where both counters wrap to 0. flip changes mid-frame have no effect until the next frame.
- Active region: HPOS = flip_q ? HACT-1-hcnt : hcnt, and VPOS = flip_q ? VACT-1-vcnt : vcnt.
- Blanking region: HPOS/VPOS equal the raw counters.

Delayed blanking
- LHBL_dly/LVBL_dly come from DLY-stage shift registers, advanced on pxl_cen only.

Pulses
- frame pulses for exactly one clk on the edge where vcnt and hcnt both become 0.
- irq pulses for exactly one clk on the edge where hcnt becomes 0 and vcnt mod IRQ_PERIOD == IRQ_PHASE and vcnt < VACT.
- frame and irq clear on the next clk regardless of pxl_cen.

Parameter legality
- Constraints: HACT < HTOTAL <= 2^HW; HS_START < HS_END <= HTOTAL; VACT < VTOTAL <= 2^VW; VS_START < VS_END <= VTOTAL; IRQ_PHASE < IRQ_PERIOD.
- Violations are caught by a simulation-only assertion.

pxl_cen stalls
- pxl_cen held 0 freezes all counters and levels.

Test Plan:
- Reset release with pxl_cen every 4th clk -> hcnt counts 0..383 and wraps; vcnt +1 per wrap; 264 lines per frame; frame pulse 1 clk wide once per 101376 pxl_cen ticks.
- Defaults, no flip -> HBL rises at hcnt=256 and falls at 0; HS high for hcnt 288..319; VBL high for vcnt 240..263; VS high for vcnt 248..250.
- Defaults -> irq pulses at hcnt=0 on vcnt 8,24,...,232 (15 pulses per frame); none on vcnt 248.
- flip raised at vcnt=100 -> HPOS/VPOS unchanged until frame start; next frame at hcnt=0, vcnt=0: HPOS=255, VPOS=239, flip_q=1.
- DLY=2 -> LHBL_dly falls 2 pxl_cen ticks after HBL rises; with DLY=5, 5 ticks; both read 0 for the first DLY ticks after reset.
- rst asserted at hcnt=200, vcnt=120 -> all outputs 0 without a clock edge; after release the first pxl_cen gives hcnt=1, vcnt=0.
